// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular FIFO of {pc, inst} pairs.
// Optional stall counter enabled by IF_ID_PERF_CNT_EN.
module if_id_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_pc,
  input  logic [DATA_W-1:0]        in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_pc,
  output logic [DATA_W-1:0]        out_pc4,
  output logic [DATA_W-1:0]        out_inst,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] inst_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Handshake flags depend on registered state only
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Head fields, forced to a NOP at pc 0 when empty
  assign out_pc   = out_valid ? pc_q[rd_ptr_q]   : '0;
  assign out_inst = out_valid ? inst_q[rd_ptr_q] : '0;
  assign out_pc4  = out_pc + DATA_W'(4);

  // Next pointer and occupancy; flush wins over both handshakes
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)
        count_d = count_q + CW'(1);
      else if (pop && !push)
        count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail on push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (push) begin
      pc_q[wr_ptr_q]   <= in_pc;
      inst_q[wr_ptr_q] <= in_inst;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic        stall_hit;

  assign stall_hit = out_valid & ~out_ready & ~flush;
  assign stall_cnt = stall_cnt_q;

  // Saturating count of cycles where ID holds off a valid head
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall_hit && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed steps plus random traffic
// checked against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_pc = '0;
  logic [31:0]       in_inst = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc4;
  logic [31:0]       out_inst;
  logic              flush = 1'b0;
  logic [1:0]        count;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  if_id_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .out_inst  (out_inst),
    .flush     (flush),
    .count     (count)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_stall = '0;
  int          npass = 0;
  int          nchk  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all();
    logic [31:0] e_pc, e_inst, e_pc4;
    int sz;
    sz     = mq.size();
    e_pc   = (sz > 0) ? mq[0].pc   : 32'd0;
    e_inst = (sz > 0) ? mq[0].inst : 32'd0;
    e_pc4  = e_pc + 32'd4;
    chk("count",     64'(count),     64'(sz));
    chk("in_ready",  64'(in_ready),  64'(sz < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(sz > 0));
    chk("out_pc",    64'(out_pc),    64'(e_pc));
    chk("out_pc4",   64'(out_pc4),   64'(e_pc4));
    chk("out_inst",  64'(out_inst),  64'(e_inst));
`ifdef IF_ID_PERF_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // One clock: drive, check current outputs, then advance the model
  task automatic step(input logic v, input logic [31:0] pc,
                      input logic [31:0] inst, input logic ordy,
                      input logic fl);
    int sz;
    ent_t e;
    @(negedge clk);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    #1 chk_all();
    sz = mq.size();
    @(posedge clk);
    if (sz > 0 && !ordy && !fl && m_stall != 32'hFFFF_FFFF)
      m_stall = m_stall + 32'd1;
    if (fl) begin
      mq.delete();
    end else begin
      if (sz > 0 && ordy) void'(mq.pop_front());
      if (v && sz < DEPTH) begin
        e.pc   = pc;
        e.inst = inst;
        mq.push_back(e);
      end
    end
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  // Reset asserted mid-cycle; outputs must clear before any edge
  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_count",     64'(count),     64'(0));
    chk("rst_out_pc",    64'(out_pc),    64'(0));
    chk("rst_out_inst",  64'(out_inst),  64'(0));
    chk("rst_out_pc4",   64'(out_pc4),   64'(4));
`ifdef IF_ID_PERF_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    mq.delete();
    m_stall = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    idle_inputs();
    #12 rst = 1'b0;

    // Single pass
    step(1, 32'h0040_0000, 32'h2008_0005, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Fill and stall, third push refused
    step(1, 32'h0, 32'h11, 0, 0);
    step(1, 32'h4, 32'h22, 0, 0);
    step(1, 32'h8, 32'h33, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Concurrent push/pop at count=1 across pointer wrap
    pc = 32'h1000;
    step(1, pc, 32'hA000, 0, 0);
    for (int i = 1; i <= 8; i++)
      step(1, pc + 32'(4 * i), 32'hA000 + 32'(i), 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Flush with concurrent push at count=2
    step(1, 32'h20, 32'h1, 0, 0);
    step(1, 32'h24, 32'h2, 0, 0);
    step(1, 32'h100, 32'h3, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("flush_no_valid", 64'(out_valid), 64'(0));

    // pc4 wrap
    step(1, 32'hFFFF_FFFC, 32'hDEAD, 0, 0);
    step(0, 0, 0, 0, 0);

    // Stall cycles with head held
    mid_reset();
    step(1, 32'h300, 32'h7, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           {$urandom, 2'b00} & 32'hFFFF_FFFC,
           $urandom,
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));
      if (i == 200) mid_reset();
    end
    step(0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
